// File: rtl/arbitro_nota_pkg.sv
// Shared encodings for the tone-generator arbiter: FSM states, note range,
// source codes and the duration counter width.
package arbitro_nota_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] ST_REPOSO   = 2'd0;
  localparam logic [1:0] ST_LIBRE    = 2'd1;
  localparam logic [1:0] ST_CANCION  = 2'd2;
  localparam logic [1:0] ST_SILENCIO = 2'd3;

  localparam logic [2:0] NOTA_MUTE = 3'd7;
  localparam logic [2:0] NOTA_MIN  = 3'd1;
  localparam logic [2:0] NOTA_MAX  = 3'd4;

  localparam logic [1:0] FUENTE_NINGUNA = 2'b00;
  localparam logic [1:0] FUENTE_LIBRE   = 2'b01;
  localparam logic [1:0] FUENTE_CANCION = 2'b10;

  // Everything the tone generator side sees, registered as one bundle.
  typedef struct packed {
    logic [2:0] nota_tono;
    logic       tono_en;
    logic [1:0] fuente;
    logic       ocupado;
  } salida_t;

  localparam salida_t SALIDA_RESET = '{nota_tono: NOTA_MUTE, tono_en: 1'b0,
                                       fuente: FUENTE_NINGUNA, ocupado: 1'b0};

  function automatic logic nota_valida(input logic [2:0] n);
    return (n >= NOTA_MIN) && (n <= NOTA_MAX);
  endfunction

endpackage

// File: rtl/arbitro_nota_if.sv
// Bundle between the two note sources / tone generator (master) and the
// arbiter (slave).
interface arbitro_nota_if;
  logic       modo;
  logic [2:0] nota_libre;
  logic       contar_libre;
  logic       cancion_valid;
  logic [2:0] cancion_nota;
  logic       cancion_ready;
  logic [2:0] nota_tono;
  logic       tono_en;
  logic [1:0] fuente;
  logic       ocupado;

  modport master (
    output modo, nota_libre, contar_libre, cancion_valid, cancion_nota,
    input  cancion_ready, nota_tono, tono_en, fuente, ocupado
  );

  modport slave (
    input  modo, nota_libre, contar_libre, cancion_valid, cancion_nota,
    output cancion_ready, nota_tono, tono_en, fuente, ocupado
  );
endinterface

// File: rtl/arbitro_nota_contador_duracion.sv
// Saturating duration counter shared by the hold and silence phases.
// sat_o is high once the count reaches limite_i; done_o is sat qualified by en_i.
module contador_duracion
  import arbitro_nota_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limite_i,
  output logic             sat_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat_o  = (cnt_q >= limite_i);
  assign done_o = en_i & sat_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !sat_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/arbitro_nota.sv
// Owns the single tone generator and shares it between free play and song
// playback, enforcing a minimum note length followed by a fixed silence.
module arbitro_nota
  import arbitro_nota_pkg::*;
#(
  parameter int MIN_CICLOS      = 16,
  parameter int SILENCIO_CICLOS = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  arbitro_nota_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIM_NOTA = CNT_W'(MIN_CICLOS - 1);
  localparam logic [CNT_W-1:0] LIM_SIL  = CNT_W'(SILENCIO_CICLOS - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       nota_q, nota_d;
  logic             latch;
  logic             cnt_clr, cnt_en, cnt_sat, cnt_done;
  logic [CNT_W-1:0] cnt_lim;
  salida_t          sal_q, sal_d;
  logic             sonando;

  assign cnt_en  = (state_q != ST_REPOSO);
  assign cnt_lim = (state_q == ST_SILENCIO) ? LIM_SIL : LIM_NOTA;
  assign cnt_clr = (state_d != state_q) | latch;

  contador_duracion u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .limite_i (cnt_lim),
    .sat_o    (cnt_sat),
    .done_o   (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    nota_d  = nota_q;
    latch   = 1'b0;
    case (state_q)
      ST_REPOSO: begin
        if (!bus.modo && bus.contar_libre && nota_valida(bus.nota_libre)) begin
          state_d = ST_LIBRE;
          nota_d  = bus.nota_libre;
        end else if (bus.modo && bus.cancion_valid) begin
          // Rests are stored as mute so the output path needs no special case.
          state_d = ST_CANCION;
          nota_d  = nota_valida(bus.cancion_nota) ? bus.cancion_nota : NOTA_MUTE;
        end
      end
      ST_LIBRE: begin
        if (bus.modo)
          state_d = ST_SILENCIO;
        else if (cnt_sat) begin
          if (!bus.contar_libre || !nota_valida(bus.nota_libre))
            state_d = ST_SILENCIO;
          else if (bus.nota_libre != nota_q) begin
            nota_d = bus.nota_libre;
            latch  = 1'b1;
          end
        end
      end
      ST_CANCION: begin
        if (!bus.modo || cnt_done)
          state_d = ST_SILENCIO;
      end
      ST_SILENCIO: begin
        if (cnt_done)
          state_d = ST_REPOSO;
      end
      default: state_d = ST_REPOSO;
    endcase
  end

  // Outputs are registered from next-state so a request shows up right after its edge.
  always_comb begin
    sonando       = ((state_d == ST_LIBRE) || (state_d == ST_CANCION)) && nota_valida(nota_d);
    sal_d         = SALIDA_RESET;
    sal_d.nota_tono = sonando ? nota_d : NOTA_MUTE;
    sal_d.tono_en   = sonando;
    sal_d.ocupado   = (state_d != ST_REPOSO);
    case (state_d)
      ST_LIBRE:    sal_d.fuente = FUENTE_LIBRE;
      ST_CANCION:  sal_d.fuente = FUENTE_CANCION;
      ST_SILENCIO: sal_d.fuente = sal_q.fuente;
      default:     sal_d.fuente = FUENTE_NINGUNA;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_REPOSO;
      nota_q  <= NOTA_MUTE;
      sal_q   <= SALIDA_RESET;
    end else begin
      state_q <= state_d;
      nota_q  <= nota_d;
      sal_q   <= sal_d;
    end
  end

  assign bus.cancion_ready = reset_n & (state_q == ST_REPOSO) & bus.modo;
  assign bus.nota_tono     = sal_q.nota_tono;
  assign bus.tono_en       = sal_q.tono_en;
  assign bus.fuente        = sal_q.fuente;
  assign bus.ocupado       = sal_q.ocupado;

endmodule
